mc_cmd_fifo: RTL
================

// Module: mc_cmd_fifo
// PURPOSE
//  Multi-channel command-driven FIFO: NUM_CH independent FIFOs behind one request/response port.
//  Each request names a channel and an op (FLUSH/READ/WRITE/PEEK) and gets exactly one response with data+err.
//  Successor to the single-channel request FIFO; sits between the test/host interface and per-stream consumers.
// PARAMETERS
//  DATA_WIDTH    32       payload width
//  MAX_CAPACITY  2**4     entries per channel; power of 2, >=2
//  NUM_CH        4        channel count, >=1
//  CH_W          $clog2(NUM_CH) or 1 if NUM_CH==1 (localparam)
// PORTS
//  clk_i      in   1           clock, rising edge
//  rst_ni     in   1           reset, asynchronous, active-low
//  req_val_i  in   1           request valid
//  req_typ_i  in   2           0:FLUSH 1:READ(pop) 2:WRITE(push) 3:PEEK
//  req_ch_i   in   CH_W        target channel
//  data_i     in   DATA_WIDTH  write payload (ignored for other ops)
//  req_rdy_o  out  1           request ready
//  rsp_val_o  out  1           response valid
//  rsp_typ_o  out  2           echo of accepted req_typ_i
//  rsp_ch_o   out  CH_W        echo of accepted req_ch_i
//  data_o     out  DATA_WIDTH  READ/PEEK data; 0 for WRITE/FLUSH/error
//  err_o      out  1           request rejected (see errors)
//  rsp_rdy_i  in   1           response ready
//  full_o     out  NUM_CH      per-channel full
//  empty_o    out  NUM_CH      per-channel empty
// BEHAVIOUR
//  - Reset (async assert, sync deassert by system): all pointers 0, rsp_val_o=0, rsp_typ_o/rsp_ch_o/data_o/err_o=0,
//    empty_o=all 1, full_o=all 0, req_rdy_o=1. Storage contents not reset. Reset mid-op drops pending response.
//  - Accept: req_val_i && req_rdy_o. req_rdy_o = !rsp_val_o || rsp_rdy_i (single response register, no bubble).
//  - Latency: response valid the cycle after accept; back-to-back accepts at 1/cycle when rsp_rdy_i=1.
//  - rsp_* held stable while rsp_val_o && !rsp_rdy_i; no new request accepted then.
//  - State updates (pointers, storage) happen at accept edge; full_o/empty_o reflect them next cycle.
//  - WRITE: if !full[ch] store data_i at wr_ptr, wr_ptr++; else err_o=1, no change.
//  - READ:  if !empty[ch] data_o=mem[rd_ptr], rd_ptr++; else err_o=1, data_o=0.
//  - PEEK:  as READ without advancing rd_ptr.
//  - FLUSH: rd_ptr<=wr_ptr (channel empty), never errors, data_o=0.
//  - req_ch_i >= NUM_CH: err_o=1, no state change, any op.
//  - Pointers $clog2(MAX_CAPACITY)+1 bits; wrap naturally; empty: ptrs equal; full: MSB differ, rest equal.
//  - Channels fully independent; op on one channel never alters another's state.
//  - Only one op per cycle, so no same-channel push/pop collision; WRITE to full channel errors even if a
//    READ of that channel is waiting in the response register (already retired).
//  - No FSM beyond response-register valid bit (IDLE/RSP); X on req_typ_i/req_ch_i when !req_val_i is ignored.
// STRUCTURE
//  - Package mc_fifo_pkg: typedef enum logic[1:0] req_typ_e {REQ_FLUSH,REQ_READ,REQ_WRITE,REQ_PEEK}.
//  - Sub-module mc_fifo_chan (one per channel, generate loop): storage array, wr/rd pointers,
//    push/pop/flush strobes in, head data/full/empty out.
//  - Top: request decode + channel range check, head-data mux, response register, handshake.
// TESTING
//  - Reset: assert rst_ni=0 mid-response -> rsp_val_o=0 immediately, empty_o=4'b1111, req_rdy_o=1.
//  - WRITE ch2 0xA5A5_0001..0x..0003, READ ch2 x3 -> data_o in order, err_o=0, empty_o[2]=1 after.
//  - Fill ch0 with 16 writes -> full_o[0]=1; 17th WRITE -> err_o=1; READ -> first value; wrap 40 push/pop pairs clean.
//  - READ/PEEK empty ch1 -> err_o=1, data_o=0; PEEK twice on non-empty -> same value, count unchanged.
//  - Hold rsp_rdy_i=0 3 cycles after accept -> rsp_* stable, req_rdy_o=0; release -> next request accepted same cycle.
//  - Interleave ch0/ch3 writes, FLUSH ch0 -> empty_o[0]=1, ch3 data intact; req_ch_i=NUM_CH -> err_o=1.

Source files
------------

// File: rtl/mc_fifo_pkg.sv
// mc_fifo_pkg: shared request opcode type for the multi-channel command FIFO
package mc_fifo_pkg;
    typedef enum logic [1:0] {REQ_FLUSH, REQ_READ, REQ_WRITE, REQ_PEEK} req_typ_e;
endpackage

// File: rtl/mc_fifo_chan.sv
// mc_fifo_chan: one channel's storage and extra-MSB wrap pointers
module mc_fifo_chan
    import mc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_CAPACITY = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW = $clog2(MAX_CAPACITY);

    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [MAX_CAPACITY];

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = flush_i ? wr_ptr_q : pop_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = wr_ptr_q == rd_ptr_q;
    assign full_o  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/mc_cmd_fifo.sv
// mc_cmd_fifo: NUM_CH independent FIFOs behind one request/response port
module mc_cmd_fifo
    import mc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_CAPACITY = 2**4,
    parameter int NUM_CH       = 4,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_val_i,
    input  logic [1:0]            req_typ_i,
    input  logic [CH_W-1:0]       req_ch_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  req_rdy_o,
    output logic                  rsp_val_o,
    output logic [1:0]            rsp_typ_o,
    output logic [CH_W-1:0]       rsp_ch_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  err_o,
    input  logic                  rsp_rdy_i,
    output logic [NUM_CH-1:0]     full_o,
    output logic [NUM_CH-1:0]     empty_o
);
    localparam int NP = 2**CH_W;

    logic [NP-1:0]         full_a, empty_a, ch_map;
    logic [DATA_WIDTH-1:0] head_a [NP];
    logic [NUM_CH-1:0]     push_v, pop_v, flush_v;
    req_typ_e              typ;
    logic                  acc, ch_ok, is_rd, err;

    logic                  rsp_val_q, rsp_val_d, rsp_err_q, rsp_err_d;
    logic [1:0]            rsp_typ_q, rsp_typ_d;
    logic [CH_W-1:0]       rsp_ch_q, rsp_ch_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    assign req_rdy_o = !rsp_val_q || rsp_rdy_i;

    always_comb begin
        typ = req_typ_e'(req_typ_i);
        acc = req_val_i && req_rdy_o;
        for (int i = 0; i < NP; i++) ch_map[i] = i < NUM_CH;
        ch_ok = ch_map[req_ch_i];
        is_rd = typ == REQ_READ || typ == REQ_PEEK;
        err   = !ch_ok || (typ == REQ_WRITE && full_a[req_ch_i]) || (is_rd && empty_a[req_ch_i]);
        for (int i = 0; i < NUM_CH; i++) begin
            push_v[i]  = acc && !err && req_ch_i == CH_W'(i) && typ == REQ_WRITE;
            pop_v[i]   = acc && !err && req_ch_i == CH_W'(i) && typ == REQ_READ;
            flush_v[i] = acc && !err && req_ch_i == CH_W'(i) && typ == REQ_FLUSH;
        end
        rsp_val_d  = acc || (rsp_val_q && !rsp_rdy_i);
        rsp_typ_d  = acc ? req_typ_i : rsp_typ_q;
        rsp_ch_d   = acc ? req_ch_i : rsp_ch_q;
        rsp_err_d  = acc ? err : rsp_err_q;
        rsp_data_d = acc ? ((is_rd && !err) ? head_a[req_ch_i] : '0) : rsp_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_val_q  <= 1'b0;
            rsp_typ_q  <= '0;
            rsp_ch_q   <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            rsp_val_q  <= rsp_val_d;
            rsp_typ_q  <= rsp_typ_d;
            rsp_ch_q   <= rsp_ch_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Index space padded to a power of two so out-of-range channels read as empty, not full
    for (genvar c = 0; c < NP; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            mc_fifo_chan #(.DATA_WIDTH(DATA_WIDTH), .MAX_CAPACITY(MAX_CAPACITY)) u_chan (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .push_i  (push_v[c]),
                .pop_i   (pop_v[c]),
                .flush_i (flush_v[c]),
                .data_i  (data_i),
                .head_o  (head_a[c]),
                .full_o  (full_a[c]),
                .empty_o (empty_a[c])
            );
        end else begin : g_off
            assign head_a[c]  = '0;
            assign full_a[c]  = 1'b0;
            assign empty_a[c] = 1'b1;
        end
    end

    assign rsp_val_o = rsp_val_q;
    assign rsp_typ_o = rsp_typ_q;
    assign rsp_ch_o  = rsp_ch_q;
    assign data_o    = rsp_data_q;
    assign err_o     = rsp_err_q;
    assign full_o    = full_a[NUM_CH-1:0];
    assign empty_o   = empty_a[NUM_CH-1:0];
endmodule
